// File: rtl/alarm_pkg.sv
// Shared encodings for the vehicle-alarm sequencer: FSM states, timer interval codes,
// and the bit layout of the synchronized switch bus.
package alarm_pkg;

  typedef enum logic [2:0] {
    StDisarmed  = 3'd0,
    StWaitClose = 3'd1,
    StArmDelay  = 3'd2,
    StArmed     = 3'd3,
    StTriggered = 3'd4,
    StAlarm     = 3'd5
  } state_e;

  localparam logic [1:0] INT_ARM_DELAY       = 2'b00;
  localparam logic [1:0] INT_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] INT_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] INT_ALARM_ON        = 2'b11;

  localparam int unsigned SyncWidth = 3;
  localparam int unsigned SyncIgn   = 0;
  localparam int unsigned SyncDrv   = 1;
  localparam int unsigned SyncPass  = 2;

  function automatic logic is_armed(state_e s);
    return s inside {StArmed, StTriggered, StAlarm};
  endfunction

endpackage

// File: rtl/alarm_sync.sv
// Two-flop synchronizer for the switch inputs; synchronous active-high reset clears both stages.
module alarm_sync #(
  parameter int unsigned Width = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Vehicle-alarm sequencer: arms on door close, triggers on door open, drives timer and siren.
// Define ALARM_PASSENGER_DELAY_EN to give the passenger door its own trigger interval.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter bit ARM_RESTART = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       expired,
  output logic [1:0] interval,
  output logic       start_timer,
  output logic       siren,
  output logic       status,
  output logic [2:0] state_dbg
);

`ifdef ALARM_PASSENGER_DELAY_EN
  localparam logic [1:0] PassInterval = INT_PASSENGER_DELAY;
`else
  localparam logic [1:0] PassInterval = INT_DRIVER_DELAY;
`endif

  logic [SyncWidth-1:0] sw_raw, sw;
  logic                 ign, drv, pass, any_door;
  logic                 load_q, exp_ok;
  state_e               state_q, state_d;
  logic [1:0]           interval_d;
  logic                 start_d;

  assign sw_raw = {door_pass, door_driver, ignition};

  alarm_sync #(
    .Width(SyncWidth)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (sw_raw),
    .q    (sw)
  );

  assign ign      = sw[SyncIgn];
  assign drv      = sw[SyncDrv];
  assign pass     = sw[SyncPass];
  assign any_door = drv | pass;

  // The timer needs the pulse cycle plus one more to load, so its flag is stale until then.
  assign exp_ok = expired & ~start_timer & ~load_q;

  always_comb begin
    state_d    = state_q;
    interval_d = interval;
    start_d    = 1'b0;
    if (ign) begin
      state_d    = StDisarmed;
      interval_d = INT_ARM_DELAY;
    end else begin
      case (state_q)
        StDisarmed: begin
          if (drv) state_d = StWaitClose;
        end
        StWaitClose: begin
          if (!any_door) begin
            state_d    = StArmDelay;
            interval_d = INT_ARM_DELAY;
            start_d    = 1'b1;
          end
        end
        StArmDelay: begin
          if (any_door) begin
            if (ARM_RESTART) start_d = 1'b1;
            else             state_d = StWaitClose;
          end else if (exp_ok) begin
            state_d = StArmed;
          end
        end
        StArmed: begin
          if (drv) begin
            state_d    = StTriggered;
            interval_d = INT_DRIVER_DELAY;
            start_d    = 1'b1;
          end else if (pass) begin
            state_d    = StTriggered;
            interval_d = PassInterval;
            start_d    = 1'b1;
          end
        end
        StTriggered: begin
          if (exp_ok) begin
            state_d    = StAlarm;
            interval_d = INT_ALARM_ON;
            start_d    = 1'b1;
          end
        end
        StAlarm: begin
          if (any_door)    start_d = 1'b1;
          else if (exp_ok) state_d = StArmed;
        end
        default: state_d = StDisarmed;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StDisarmed;
      interval    <= INT_ARM_DELAY;
      start_timer <= 1'b0;
      siren       <= 1'b0;
      status      <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      interval    <= interval_d;
      start_timer <= start_d;
      siren       <= (state_d == StAlarm);
      status      <= is_armed(state_d);
      load_q      <= start_timer;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequencing controller for the vehicle-alarm timer. Watches ignition and door switches, selects which delay interval the timer runs, pulses its `start_timer`, and consumes `expired` to advance through arm, trigger and siren phases. Sits between the switch inputs and the timer/siren in the top level; the timer's `value` input is driven from a parameter lookup indexed by `interval`.

## Interface
- `ARM_RESTART`, default 1: 1 = a door reopening during ARM_DELAY restarts the arm delay; 0 = it returns the FSM to WAIT_CLOSE.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high; one clock; all state updates on rising `clock`.
- `ignition` in 1: ignition key on.
- `door_driver` in 1: driver door open.
- `door_pass` in 1: passenger door open.
- `expired` in 1: from timer; 1 when the countdown is at zero.
- `interval` out 2: 00 T_ARM_DELAY, 01 T_DRIVER_DELAY, 10 T_PASSENGER_DELAY, 11 T_ALARM_ON.
- `start_timer` out 1: one-cycle pulse that loads the timer.
- `siren` out 1: siren enable.
- `status` out 1: status LED; 1 in ARMED, TRIGGERED and ALARM.
- `state_dbg` out 3: current state encoding.

## Operation
- States: DISARMED, WAIT_CLOSE, ARM_DELAY, ARMED, TRIGGERED, ALARM.
- Priority each cycle: `reset` > `ignition` = 1 (go to DISARMED from any state) > state-specific rules.
- DISARMED:
  - `ignition` = 0 and `door_driver` = 1 → WAIT_CLOSE.
- WAIT_CLOSE:
  - Both doors closed → ARM_DELAY, interval 00.
- ARM_DELAY:
  - Any door open → restart (ARM_RESTART = 1) or WAIT_CLOSE (ARM_RESTART = 0).
  - `expired` → ARMED.
- ARMED:
  - `door_driver` → TRIGGERED, interval 01.
  - Else `door_pass` → TRIGGERED, interval 10.
  - Both open in the same cycle → driver wins.
- TRIGGERED:
  - `expired` → ALARM, interval 11.
  - Door activity is ignored.
- ALARM:
  - `siren` = 1.
  - While any door is open, the interval is restarted every cycle.
  - `expired` with both doors closed → ARMED.
- Restart means: `start_timer` pulses again next cycle, `interval` unchanged.

## Timing
- Reset values:
  - State DISARMED.
  - `interval` = 00, `start_timer` = 0, `siren` = 0, `status` = 0, `state_dbg` = 000.
- Synchronizer: switch inputs pass through a 2-flop synchronizer. A change sampled at edge k is seen by the FSM at edge k+2, and the state changes at edge k+2.
- Outputs are registered (Moore):
  - `interval`, `siren` and `status` change in the first cycle of the new state.
  - `start_timer` = 1 in exactly that first cycle of each timed state entry or restart.
- `expired` is ignored:
  - in any cycle where `start_timer` = 1;
  - in the cycle immediately after it (timer load latency).
- `expired` is sampled from the second cycle after the pulse onward.
- Reset asserted mid-ALARM: `siren` = 0 on the cycle after the reset edge; no further `start_timer` pulse.
- `ignition` rising in TRIGGERED on the same cycle as `expired`: go to DISARMED; the siren never asserts.
- Zero-length interval (timer value 0): `expired` is already 1 when first sampled, so the state advances 2 cycles after the pulse.

## Configuration
- `ALARM_PASSENGER_DELAY_EN` defined: passenger-door trigger uses interval 10.
- Undefined: passenger door uses interval 01, same as driver; code 10 is never emitted.

## Structure
- Package `alarm_pkg`:
  - State encodings (3-bit).
  - Interval codes INT_ARM_DELAY = 2'b00, INT_DRIVER_DELAY = 2'b01, INT_PASSENGER_DELAY = 2'b10, INT_ALARM_ON = 2'b11.
- Sub-module `alarm_sync`: 2-flop synchronizer, 3 bits wide, reset to 0.
- FSM and output registers live in `alarm_controller`.

## Test plan
- Arming: reset, `ignition` = 0, `door_driver` 1 then 0.
  - WAIT_CLOSE, then ARM_DELAY with `interval` = 00 and one `start_timer` pulse.
  - Force `expired` from the 3rd cycle → ARMED, `status` = 1.
- Arm restart: reopen `door_pass` for 4 cycles during ARM_DELAY.
  - ARM_RESTART = 1: new `start_timer` pulse each of those cycles, state stays ARM_DELAY.
  - ARM_RESTART = 0: WAIT_CLOSE.
- Trigger to siren: in ARMED raise `door_driver`.
  - TRIGGERED, `interval` = 01.
  - `expired` → ALARM with `interval` = 11, `siren` = 1, one pulse.
- Siren hold: keep a door open in ALARM for 10 cycles with `expired` = 1.
  - 10 pulses, `siren` stays 1.
  - Close the door, `expired` → ARMED, `siren` = 0.
- Disarm race: in TRIGGERED assert `ignition` and `expired` on the same cycle → DISARMED, `siren` never 1.
- Passenger path: in ARMED raise `door_pass`.
  - With macro: `interval` = 10.
  - Without macro: `interval` = 01.
  - Both doors same cycle: 01.
  - Then reset mid-ALARM → all outputs 0 on the next cycle.
